// File: rtl/key_event_ctrl.sv
// Push-key debounce and press-event capture with a small Avalon-MM register file.
// Keys are active-low on the pins; all register views present 1 = pressed.
module key_event_ctrl #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CAPTURE_RELEASE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_STATE = 2'd0;
    localparam logic [1:0] ADDR_RAW   = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    logic [WIDTH-1:0]            sync1;
    logic [WIDTH-1:0]            raw;
    logic [WIDTH-1:0]            state;
    logic [WIDTH-1:0]            state_nxt;
    logic [WIDTH-1:0][CNT_W-1:0] cnt;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0]            edge_cap;
    logic [WIDTH-1:0]            edge_nxt;
    logic [WIDTH-1:0]            edge_set;
    logic [WIDTH-1:0]            edge_clr;
    logic [WIDTH-1:0]            mask;
    logic [WIDTH-1:0]            mask_nxt;
    logic [31:0]                 rd_nxt;
    logic                        bus_wr;
    logic                        unused_wdata;

    // Bits above WIDTH-1 are intentionally ignored on writes.
    assign unused_wdata = ^writedata;
    assign bus_wr       = chipselect & write;

    // Per-key debounce: a level is accepted only after DEBOUNCE_CYCLES of disagreement.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        edge_set  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (raw[i] == state[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                cnt_nxt[i]   = '0;
                state_nxt[i] = ~state[i];
                edge_set[i]  = ~state[i] | (CAPTURE_RELEASE != 0);
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Register writes; a new event outranks a simultaneous W1C on the same bit.
    always_comb begin
        mask_nxt = mask;
        edge_clr = '0;
        if (bus_wr && address == ADDR_MASK) begin
            mask_nxt = writedata[WIDTH-1:0];
        end
        if (bus_wr && address == ADDR_EDGE) begin
            edge_clr = writedata[WIDTH-1:0];
        end
        edge_nxt = (edge_cap & ~edge_clr) | edge_set;
    end

    always_comb begin
        rd_nxt = '0;
        case (address)
            ADDR_STATE: rd_nxt = 32'(state);
            ADDR_RAW:   rd_nxt = 32'(raw);
            ADDR_MASK:  rd_nxt = 32'(mask);
            ADDR_EDGE:  rd_nxt = 32'(edge_cap);
            default:    rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            raw      <= '0;
            state    <= '0;
            cnt      <= '0;
            edge_cap <= '0;
            mask     <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            sync1    <= ~in_port;
            raw      <= sync1;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            edge_cap <= edge_nxt;
            mask     <= mask_nxt;
            readdata <= rd_nxt;
            irq      <= |(edge_cap & mask);
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a 4-cycle debounce; a second instance
// captures release edges.
module tb_key_event_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    logic [3:0]  in_port_r;
    logic [1:0]  address_r;
    logic        chipselect_r;
    logic        write_r;
    logic [31:0] writedata_r;
    logic [31:0] readdata_r;
    logic        irq_r;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] v;

    always #5 clk = ~clk;

    key_event_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CAPTURE_RELEASE(0)) u_dut (
        .clk(clk), .reset(reset), .in_port(in_port), .address(address),
        .chipselect(chipselect), .write(write), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    key_event_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CAPTURE_RELEASE(1)) u_rel (
        .clk(clk), .reset(reset), .in_port(in_port_r), .address(address_r),
        .chipselect(chipselect_r), .write(write_r), .writedata(writedata_r),
        .readdata(readdata_r), .irq(irq_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] val);
        address = a;
        tick();
        val = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        in_port      = 4'hF;
        address      = 2'd0;
        chipselect   = 1'b0;
        write        = 1'b0;
        writedata    = '0;
        in_port_r    = 4'hF;
        address_r    = 2'd0;
        chipselect_r = 1'b0;
        write_r      = 1'b0;
        writedata_r  = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state and quiet exit
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd(2'd0, v); chk("rst_state", v, 32'h0);
        rd(2'd1, v); chk("rst_raw", v, 32'h0);
        rd(2'd2, v); chk("rst_mask", v, 32'h0);
        address = 2'd3;
        repeat (20) tick();
        chk("rst_edge_20cyc", readdata, 32'h0);
        chk("rst_irq_20cyc", 32'(irq), 32'h0);

        // Key0 press: state updates exactly 6 cycles after the pin
        address = 2'd0;
        in_port = 4'hE;
        repeat (6) tick();
        chk("press_state_c6", readdata, 32'h0);
        tick();
        chk("press_state_c7", readdata, 32'h1);
        rd(2'd3, v); chk("press_edge", v, 32'h1);
        rd(2'd1, v); chk("press_raw", v, 32'h1);
        chk("press_irq_masked", 32'(irq), 32'h0);

        // Mask, re-press key0, irq timing and W1C
        wr(2'd3, 32'h1);
        wr(2'd2, 32'h1);
        rd(2'd2, v); chk("mask_rb", v, 32'h1);
        in_port = 4'hF;
        repeat (10) tick();
        rd(2'd0, v); chk("rel0_state", v, 32'h0);
        rd(2'd3, v); chk("rel0_edge", v, 32'h0);
        chk("rel0_irq", 32'(irq), 32'h0);
        in_port = 4'hE;
        repeat (6) tick();
        chk("irq_c6", 32'(irq), 32'h0);
        chk("edge_c6", readdata, 32'h0);
        tick();
        chk("irq_c7", 32'(irq), 32'h1);
        chk("edge_c7", readdata, 32'h1);
        wr(2'd3, 32'h1);
        chk("irq_at_clr", 32'(irq), 32'h1);
        tick();
        chk("irq_after_clr", 32'(irq), 32'h0);
        chk("edge_after_clr", readdata, 32'h0);

        // Key2 glitches of 3 cycles are rejected
        for (int k = 0; k < 5; k++) begin
            in_port = 4'hA;
            repeat (3) tick();
            in_port = 4'hE;
            repeat (3) tick();
        end
        repeat (6) tick();
        rd(2'd0, v); chk("glitch_state", v, 32'h1);
        rd(2'd3, v); chk("glitch_edge", v, 32'h0);
        chk("glitch_irq", 32'(irq), 32'h0);

        // Key1 event coincides with W1C of bit 1: set wins
        in_port = 4'hC;
        repeat (5) tick();
        wr(2'd3, 32'h2);
        rd(2'd3, v); chk("setwin_edge", v, 32'h2);
        rd(2'd0, v); chk("setwin_state", v, 32'h3);
        chk("setwin_irq", 32'(irq), 32'h0);
        wr(2'd3, 32'h2);
        rd(2'd3, v); chk("setwin_cleared", v, 32'h0);

        // Release key0 without release capture
        in_port = 4'hD;
        repeat (8) tick();
        rd(2'd0, v); chk("norel_state", v, 32'h2);
        rd(2'd3, v); chk("norel_edge", v, 32'h0);

        // Release capture instance
        in_port_r = 4'hE;
        address_r = 2'd3;
        repeat (8) tick();
        chk("rel_press_edge", readdata_r, 32'h1);
        writedata_r  = 32'h1;
        chipselect_r = 1'b1;
        write_r      = 1'b1;
        tick();
        chipselect_r = 1'b0;
        write_r      = 1'b0;
        tick();
        chk("rel_clr_edge", readdata_r, 32'h0);
        in_port_r = 4'hF;
        repeat (8) tick();
        chk("rel_release_edge", readdata_r, 32'h1);
        address_r = 2'd0;
        tick();
        chk("rel_release_state", readdata_r, 32'h0);
        chk("rel_irq_masked", 32'(irq_r), 32'h0);

        // Reset mid-debounce discards the count
        in_port = 4'h7;
        repeat (4) tick();
        reset   = 1'b1;
        in_port = 4'hF;
        repeat (2) tick();
        reset = 1'b0;
        chk("midrst_irq", 32'(irq), 32'h0);
        address = 2'd3;
        repeat (10) tick();
        chk("midrst_edge", readdata, 32'h0);
        rd(2'd0, v); chk("midrst_state", v, 32'h0);
        rd(2'd2, v); chk("midrst_mask", v, 32'h0);
        chk("midrst_irq_late", 32'(irq), 32'h0);
        address_r = 2'd3;
        tick();
        chk("midrst_rel_edge", readdata_r, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
